sfx_arbiter: RTL and testbench

SFX_ARBITER -- requirements
Module: sfx_arbiter

---
 rtl/sfx_pkg.sv | 44 ++++
 rtl/tone_div.sv | 40 ++++
 rtl/sfx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sfx_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared types and helpers for the sound-effect arbiter: event codes (which
// double as priorities), FSM states and counter-sizing helpers.
package sfx_pkg;

  localparam int unsigned NumEvents = 4;

  // Event codes; a numerically larger code has strictly higher priority.
  typedef enum logic [1:0] {
    EvWall = 2'd0,
    EvHit  = 2'd1,
    EvGoal = 2'd2,
    EvWin  = 2'd3
  } sfx_event_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StGap  = 2'd2
  } sfx_state_e;

  localparam sfx_event_e PrioLowest  = EvWall;
  localparam sfx_event_e PrioHighest = EvWin;

  // Highest-priority set bit of a request vector indexed by event code.
  // Returns PrioLowest when nothing is set; callers gate on |reqs.
  function automatic sfx_event_e sfx_highest(input logic [NumEvents-1:0] reqs);
    sfx_event_e ev;
    ev = PrioLowest;
    for (int i = 0; i < NumEvents; i++) begin
      if (reqs[i]) ev = sfx_event_e'(2'(i));
    end
    return ev;
  endfunction

  function automatic int unsigned sfx_max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold max_val-1 (counters are loaded with value-1); never zero.
  function automatic int unsigned sfx_cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/tone_div.sv
// Loadable half-period down-counter plus toggle flop producing the square wave.
// Load restarts the wave low; run counts/toggles; neither parks everything at 0.
module tone_div #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_run,
  input  logic [W-1:0] i_half_m1,
  output logic         o_tone
);

  logic [W-1:0] r_cnt;
  logic         r_tone;

  // Half-period counter and output toggle flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= i_half_m1;
      r_tone <= 1'b0;
    end else if (i_run) begin
      if (r_cnt == '0) begin
        r_tone <= ~r_tone;
        r_cnt  <= i_half_m1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end
  end

  assign o_tone = r_tone;

endmodule

// File: rtl/sfx_arbiter.sv
// Priority arbiter for game sound effects: picks the highest-priority event,
// plays its tone for a fixed duration, then holds a silent gap.
// Optional feature: define SFX_PENDING_EN to remember blocked requests and
// replay the highest one after the gap; otherwise blocked requests are dropped.
module sfx_arbiter
  import sfx_pkg::*;
#(
  parameter int unsigned HALF_HIT  = 25000,
  parameter int unsigned HALF_WALL = 50000,
  parameter int unsigned HALF_GOAL = 12500,
  parameter int unsigned HALF_WIN  = 6250,
  parameter int unsigned DUR_SHORT = 2500000,
  parameter int unsigned DUR_LONG  = 7500000,
  parameter int unsigned GAP       = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       wall,
  input  logic       goal,
  input  logic       win,
  input  logic       enable,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] cur_event
);

  localparam int unsigned HalfW = sfx_cnt_width(
      sfx_max2(sfx_max2(HALF_HIT, HALF_WALL), sfx_max2(HALF_GOAL, HALF_WIN)));
  localparam int unsigned DurW = sfx_cnt_width(sfx_max2(sfx_max2(DUR_SHORT, DUR_LONG), GAP));

  localparam logic [HalfW-1:0] HalfHitM1  = HalfW'(HALF_HIT - 1);
  localparam logic [HalfW-1:0] HalfWallM1 = HalfW'(HALF_WALL - 1);
  localparam logic [HalfW-1:0] HalfGoalM1 = HalfW'(HALF_GOAL - 1);
  localparam logic [HalfW-1:0] HalfWinM1  = HalfW'(HALF_WIN - 1);
  localparam logic [DurW-1:0]  DurShortM1 = DurW'(DUR_SHORT - 1);
  localparam logic [DurW-1:0]  DurLongM1  = DurW'(DUR_LONG - 1);
  localparam logic [DurW-1:0]  GapM1      = DurW'(GAP - 1);

  sfx_state_e            r_state, w_state_d;
  sfx_event_e            r_event, w_event_d;
  logic [DurW-1:0]       r_dur, w_dur_d;
  logic                  r_win_q, r_win_arm;
  logic [NumEvents-1:0]  w_req, w_pend, w_cand;
  sfx_event_e            w_req_top, w_cand_top;
  logic                  w_win_req, w_start, w_load, w_run;
  logic [HalfW-1:0]      w_half_m1;

  // r_win_arm stays low after reset until win is seen low, so a win level held
  // across reset release is not mistaken for a fresh rising edge.
  assign w_win_req = win & ~r_win_q & r_win_arm;
  assign w_req     = {w_win_req, goal, hit, wall} & {NumEvents{enable}};
  assign w_cand    = w_req | w_pend;
  assign w_req_top  = sfx_highest(w_req);
  assign w_cand_top = sfx_highest(w_cand);

  // Win edge detector and post-reset arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_q   <= 1'b0;
      r_win_arm <= 1'b0;
    end else begin
      r_win_q <= win;
      if (!win) r_win_arm <= 1'b1;
    end
  end

`ifdef SFX_PENDING_EN
  logic [NumEvents-1:0] r_pend, w_pend_d, w_served;

  assign w_served = w_start ? (4'b0001 << w_event_d) : '0;

  // Every request not served this cycle (plus what was already waiting) stays pending.
  always_comb begin
    w_pend_d = r_pend;
    if (!enable) w_pend_d = '0;
    else         w_pend_d = (r_pend | w_req) & ~w_served;
  end

  // Pending request bits, one per event code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '0;
    else     r_pend <= w_pend_d;
  end

  assign w_pend = r_pend;
`else
  assign w_pend = '0;
`endif

  // State, current event and shared duration/gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_event <= EvWall;
      r_dur   <= '0;
    end else begin
      r_state <= w_state_d;
      r_event <= w_event_d;
      r_dur   <= w_dur_d;
    end
  end

  // Next-state: start, preempt, count down tone and gap.
  always_comb begin
    w_state_d = r_state;
    w_event_d = r_event;
    w_dur_d   = r_dur;
    w_start   = 1'b0;
    if (!enable) begin
      w_state_d = StIdle;
      w_dur_d   = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (|w_cand) begin
            w_start   = 1'b1;
            w_event_d = w_cand_top;
          end
        end
        StPlay: begin
          if (|w_req && (w_req_top > r_event)) begin
            w_start   = 1'b1;
            w_event_d = w_req_top;
          end else if (r_dur == '0) begin
            w_state_d = StGap;
            w_dur_d   = GapM1;
          end else begin
            w_dur_d = r_dur - 1'b1;
          end
        end
        StGap: begin
          if (|w_req && (w_req_top > r_event)) begin
            w_start   = 1'b1;
            w_event_d = w_req_top;
          end else if (r_dur == '0) begin
            w_state_d = StIdle;
            w_dur_d   = '0;
          end else begin
            w_dur_d = r_dur - 1'b1;
          end
        end
        default: begin
          w_state_d = StIdle;
          w_dur_d   = '0;
        end
      endcase
      if (w_start) begin
        w_state_d = StPlay;
        w_dur_d   = ((w_event_d == EvGoal) || (w_event_d == EvWin)) ? DurLongM1 : DurShortM1;
      end
    end
  end

  // Outputs and tone-generator controls; half-period follows the event being played.
  always_comb begin
    busy   = (r_state != StIdle);
    w_load = w_start;
    w_run  = (w_state_d == StPlay) && !w_start;
    case (w_event_d)
      EvWall:  w_half_m1 = HalfWallM1;
      EvHit:   w_half_m1 = HalfHitM1;
      EvGoal:  w_half_m1 = HalfGoalM1;
      default: w_half_m1 = HalfWinM1;
    endcase
  end

  assign cur_event = r_event;

  tone_div #(
    .W (HalfW)
  ) u_tone_div (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_run     (w_run),
    .i_half_m1 (w_half_m1),
    .o_tone    (speaker)
  );

endmodule

// File: tb/tb_sfx_arbiter.sv
// Bench for sfx_arbiter with short tones. Expected output samples are queued
// with their cycle number as stimulus is driven and compared on the falling edge.
module tb_sfx_arbiter;

  logic       clk, rst, hit, wall, goal, win, enable;
  logic       speaker, busy;
  logic [1:0] cur_event;

  int cyc;
  int n_checks;
  int n_fail;

  typedef struct {
    int         c;
    string      tag;
    bit         chk_spk;
    logic       spk;
    logic       bsy;
    bit         chk_ev;
    logic [1:0] ev;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  sfx_arbiter #(
    .HALF_HIT  (4),
    .HALF_WALL (6),
    .HALF_GOAL (2),
    .HALF_WIN  (1),
    .DUR_SHORT (32),
    .DUR_LONG  (64),
    .GAP       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hit       (hit),
    .wall      (wall),
    .goal      (goal),
    .win       (win),
    .enable    (enable),
    .speaker   (speaker),
    .busy      (busy),
    .cur_event (cur_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue an expectation; entries must be pushed in cycle order.
  task automatic exp_at(input int c, input string tag, input bit cs, input logic s,
                        input logic b, input bit ce, input logic [1:0] e);
    exp_t x;
    x.c = c; x.tag = tag; x.chk_spk = cs; x.spk = s; x.bsy = b; x.chk_ev = ce; x.ev = e;
    sb.push_back(x);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.c < cyc) begin
        check_val({mon_e.tag, "_missed"}, cyc, mon_e.c);
      end else begin
        check_val({mon_e.tag, "_busy"}, int'(busy), int'(mon_e.bsy));
        if (mon_e.chk_spk) check_val({mon_e.tag, "_spk"}, int'(speaker), int'(mon_e.spk));
        if (mon_e.chk_ev)  check_val({mon_e.tag, "_ev"}, int'(cur_event), int'(mon_e.ev));
      end
    end
  end

  initial begin
    int t;
    cyc = 0; n_checks = 0; n_fail = 0;
    rst = 1'b1; hit = 1'b0; wall = 1'b0; goal = 1'b0; win = 1'b0; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_spk", int'(speaker), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_ev", int'(cur_event), 0);
    rst = 1'b0;

    // Single hit tone: timing of start, toggles, end of play and gap.
    t = 10;
    exp_at(t + 1,  "hit_start", 1, 1'b0, 1'b1, 1, 2'd1);
    exp_at(t + 4,  "hit_pre",   1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 5,  "hit_rise",  1, 1'b1, 1'b1, 0, 2'd0);
    exp_at(t + 8,  "hit_hi",    1, 1'b1, 1'b1, 0, 2'd0);
    exp_at(t + 9,  "hit_fall",  1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 13, "hit_rise2", 1, 1'b1, 1'b1, 0, 2'd0);
    exp_at(t + 32, "hit_last",  1, 1'b1, 1'b1, 1, 2'd1);
    exp_at(t + 33, "hit_gap",   1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 37, "hit_gapq",  1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 40, "hit_gapend", 1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 41, "hit_idle",  1, 1'b0, 1'b0, 1, 2'd1);
    go_to(t); hit = 1'b1; go_to(t + 1); hit = 1'b0;

    // Goal preempts a wall tone and reloads counters.
    t = 60;
    exp_at(t + 1,  "wall_start", 1, 1'b0, 1'b1, 1, 2'd0);
    exp_at(t + 7,  "wall_rise",  1, 1'b1, 1'b1, 0, 2'd0);
    exp_at(t + 10, "wall_hi",    1, 1'b1, 1'b1, 1, 2'd0);
    exp_at(t + 11, "goal_pre",   1, 1'b0, 1'b1, 1, 2'd2);
    exp_at(t + 12, "goal_lo",    1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 13, "goal_rise",  1, 1'b1, 1'b1, 0, 2'd0);
    exp_at(t + 15, "goal_fall",  1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 74, "goal_last",  0, 1'b0, 1'b1, 1, 2'd2);
    exp_at(t + 75, "goal_gap",   1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 82, "goal_gapend", 0, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 83, "goal_idle",  1, 1'b0, 1'b0, 0, 2'd0);
    go_to(t); wall = 1'b1; go_to(t + 1); wall = 1'b0;
    go_to(t + 10); goal = 1'b1; go_to(t + 11); goal = 1'b0;

    // Hit and wall together: hit wins, wall dropped or deferred.
    t = 150;
    exp_at(t + 1,  "hw_start", 1, 1'b0, 1'b1, 1, 2'd1);
    exp_at(t + 41, "hw_idle",  1, 1'b0, 1'b0, 0, 2'd0);
`ifdef SFX_PENDING_EN
    exp_at(t + 42, "hw_replay", 1, 1'b0, 1'b1, 1, 2'd0);
    exp_at(t + 48, "hw_rrise",  1, 1'b1, 1'b1, 0, 2'd0);
    exp_at(t + 81, "hw_rgap",   1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 82, "hw_rdone",  1, 1'b0, 1'b0, 0, 2'd0);
`else
    exp_at(t + 42, "hw_drop",  1, 1'b0, 1'b0, 0, 2'd0);
    exp_at(t + 60, "hw_quiet", 1, 1'b0, 1'b0, 0, 2'd0);
`endif
    go_to(t); hit = 1'b1; wall = 1'b1; go_to(t + 1); hit = 1'b0; wall = 1'b0;

    // Equal-priority request during play must not restart the tone.
    t = 240;
    exp_at(t + 1,  "eq_start", 1, 1'b0, 1'b1, 1, 2'd1);
    exp_at(t + 5,  "eq_rise",  1, 1'b1, 1'b1, 0, 2'd0);
    exp_at(t + 6,  "eq_norst", 1, 1'b1, 1'b1, 0, 2'd0);
    exp_at(t + 9,  "eq_fall",  1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 41, "eq_idle",  1, 1'b0, 1'b0, 0, 2'd0);
`ifdef SFX_PENDING_EN
    exp_at(t + 42, "eq_replay", 1, 1'b0, 1'b1, 1, 2'd1);
    exp_at(t + 82, "eq_rdone",  1, 1'b0, 1'b0, 0, 2'd0);
`else
    exp_at(t + 42, "eq_drop",  1, 1'b0, 1'b0, 0, 2'd0);
`endif
    go_to(t); hit = 1'b1; go_to(t + 1); hit = 1'b0;
    go_to(t + 5); hit = 1'b1; go_to(t + 6); hit = 1'b0;

    // Win level held 200 cycles plays exactly one tone.
    t = 330;
    exp_at(t + 1,   "win_start", 1, 1'b0, 1'b1, 1, 2'd3);
    exp_at(t + 2,   "win_rise",  1, 1'b1, 1'b1, 0, 2'd0);
    exp_at(t + 3,   "win_fall",  1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 72,  "win_gapend", 1, 1'b0, 1'b1, 0, 2'd0);
    exp_at(t + 73,  "win_idle",  1, 1'b0, 1'b0, 1, 2'd3);
    exp_at(t + 120, "win_once",  1, 1'b0, 1'b0, 0, 2'd0);
    exp_at(t + 199, "win_once2", 1, 1'b0, 1'b0, 0, 2'd0);
    go_to(t); win = 1'b1; go_to(t + 200); win = 1'b0;

    // Enable dropped mid-tone silences next cycle; requests ignored while low.
    t = 540;
    exp_at(t + 1,  "en_start", 1, 1'b0, 1'b1, 1, 2'd2);
    exp_at(t + 3,  "en_rise",  1, 1'b1, 1'b1, 0, 2'd0);
    exp_at(t + 11, "en_hi",    1, 1'b1, 1'b1, 0, 2'd0);
    exp_at(t + 12, "en_off",   1, 1'b0, 1'b0, 0, 2'd0);
    exp_at(t + 16, "en_ign",   1, 1'b0, 1'b0, 0, 2'd0);
    exp_at(t + 19, "en_ign2",  1, 1'b0, 1'b0, 0, 2'd0);
    go_to(t); goal = 1'b1; go_to(t + 1); goal = 1'b0;
    go_to(t + 11); enable = 1'b0;
    go_to(t + 15); hit = 1'b1; go_to(t + 16); hit = 1'b0;
    go_to(t + 20); enable = 1'b1;

    // Reset mid-play silences at once; win held across release does not fire.
    t = 580;
    exp_at(t + 5,  "rp_hi",     1, 1'b1, 1'b1, 1, 2'd1);
    exp_at(t + 12, "rp_nowin",  1, 1'b0, 1'b0, 1, 2'd0);
    exp_at(t + 30, "rp_nowin2", 1, 1'b0, 1'b0, 0, 2'd0);
    exp_at(t + 51, "rp_win",    1, 1'b0, 1'b1, 1, 2'd3);
    exp_at(t + 123, "rp_done",  1, 1'b0, 1'b0, 0, 2'd0);
    go_to(t); hit = 1'b1; go_to(t + 1); hit = 1'b0;
    go_to(t + 6);
    rst = 1'b1;
    #1;
    check_val("arst_spk", int'(speaker), 0);
    check_val("arst_busy", int'(busy), 0);
    check_val("arst_ev", int'(cur_event), 0);
    go_to(t + 8); win = 1'b1;
    go_to(t + 10); rst = 1'b0;
    go_to(t + 40); win = 1'b0;
    go_to(t + 50); win = 1'b1;
    go_to(t + 60); win = 1'b0;

    go_to(t + 130);
    check_val("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
